// File: rtl/frogger_pkg.sv
// Shared definitions for the frog controller.
// Holds the playfield geometry, tile-type codes, the button/direction encoding,
// the pending-move record and a small saturating-step helper for tile coordinates.
package frogger_pkg;

    localparam int GAME_WIDTH     = 20;
    localparam int GAME_HEIGHT    = 15;
    localparam int START_X        = 10;
    localparam int START_Y        = 14;
    localparam int DEBOUNCE_LIMIT = 250000;
    localparam int MAX_SCORE      = 99;

    localparam logic [2:0] TILE_WALL  = 3'd0;
    localparam logic [2:0] TILE_ROAD  = 3'd1;
    localparam logic [2:0] TILE_WATER = 3'd2;
    localparam logic [2:0] TILE_SAFE  = 3'd3;
    localparam logic [2:0] TILE_LILY  = 3'd4;

    // Encoding doubles as the button index and as the request priority
    // (lower value wins when several buttons fire in the same cycle).
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } pending_t;

    // One-tile step along an axis; a step that would leave 0..max_pos is
    // swallowed and the coordinate is returned unchanged.
    function automatic logic [5:0] step_clamp(input logic [5:0] pos,
                                              input logic       inc,
                                              input logic [5:0] max_pos);
        logic [5:0] result;
        result = pos;
        if (inc) begin
            if (pos < max_pos) result = pos + 6'd1;
        end else begin
            if (pos != 6'd0) result = pos - 6'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/frogger_ctrl_debounce_filter.sv
// Button conditioning: two-flop synchronizer followed by a stability filter.
// The filtered level only follows the synchronized input after it has differed
// from the current level for c_DEBOUNCE_LIMIT consecutive clocks. A one-clock
// press pulse accompanies every 0->1 change of the filtered level.
//
// Ports:
//   i_Clk       system clock
//   i_Rst_L     synchronous active-low reset (clears filter to 0)
//   i_Raw       raw asynchronous button, active high
//   o_Debounced filtered button level
//   o_Press     one-clock pulse on the filtered rising edge
module debounce_filter
    import frogger_pkg::*;
#(
    parameter int c_DEBOUNCE_LIMIT = DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Debounced,
    output logic o_Press
);

    localparam int CNT_W = (c_DEBOUNCE_LIMIT > 1) ? $clog2(c_DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(c_DEBOUNCE_LIMIT - 1);

    logic             sync_meta;
    logic             sync_q;
    logic             level;
    logic             press;
    logic [CNT_W-1:0] count;

    // Down-counter reloads whenever input and level agree, so any bounce back
    // restarts the stability window. Terminal count on a differing input means
    // the input has been stable for the full window.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            count     <= RELOAD;
        end else begin
            sync_meta <= i_Raw;
            sync_q    <= sync_meta;
            press     <= 1'b0;
            if (sync_q == level) begin
                count <= RELOAD;
            end else if (count == '0) begin
                level <= sync_q;
                press <= sync_q;
                count <= RELOAD;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign o_Debounced = level;
    assign o_Press     = press;

endmodule

// File: rtl/frogger_ctrl.sv
// Frog position and score controller.
// Debounced button presses are latched into a one-entry pending move that is
// committed only during vertical blanking. Every cycle the current tile is
// judged for hazards (car, water, top row); a hazard respawns the frog and
// beats any move committing in the same cycle. Landing on a lily pad in the
// top row scores a point, saturating at c_MAX_SCORE.
//
// Ports:
//   i_Clk, i_Rst_L          clock, synchronous active-low reset
//   i_Score                 score feedback from top level (not used)
//   i_Up/Down/Left/Right_Mvt raw buttons, active high, asynchronous
//   i_Collided              frog tile matches a car tile
//   i_Col_Count_Div         raster column / 32 (not used)
//   i_Row_Count_Div         raster row / 32, blanking when >= c_GAME_HEIGHT
//   i_Bitmap_Data           tile type under the frog
//   o_Frogger_X/Y           frog tile column/row
//   o_Score                 goals scored
module frogger_ctrl
    import frogger_pkg::*;
#(
    parameter int c_GAME_WIDTH     = GAME_WIDTH,
    parameter int c_GAME_HEIGHT    = GAME_HEIGHT,
    parameter int c_START_X        = START_X,
    parameter int c_START_Y        = START_Y,
    parameter int c_DEBOUNCE_LIMIT = DEBOUNCE_LIMIT,
    parameter int c_MAX_SCORE      = MAX_SCORE
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [6:0] i_Score,
    input  logic       i_Up_Mvt,
    input  logic       i_Down_Mvt,
    input  logic       i_Left_Mvt,
    input  logic       i_Right_Mvt,
    input  logic       i_Collided,
    input  logic [4:0] i_Col_Count_Div,
    input  logic [4:0] i_Row_Count_Div,
    input  logic [2:0] i_Bitmap_Data,
    output logic [5:0] o_Frogger_X,
    output logic [5:0] o_Frogger_Y,
    output logic [6:0] o_Score
);

    localparam logic [5:0] START_X_V = 6'(c_START_X);
    localparam logic [5:0] START_Y_V = 6'(c_START_Y);
    localparam logic [5:0] MAX_X_V   = 6'(c_GAME_WIDTH - 1);
    localparam logic [5:0] MAX_Y_V   = 6'(c_GAME_HEIGHT - 1);
    localparam logic [4:0] BLANK_ROW = 5'(c_GAME_HEIGHT);
    localparam logic [6:0] MAX_SCORE_V = 7'(c_MAX_SCORE);

    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;

    logic [5:0] frog_x, frog_x_next;
    logic [5:0] frog_y, frog_y_next;
    logic [6:0] score, score_next;
    pending_t   pending, pending_next;

    logic       req_valid;
    dir_e       req_dir;
    logic       blanking;
    logic       at_top;
    logic       hazard;
    logic       goal;

    // Bit index matches dir_e encoding.
    assign btn_raw = {i_Right_Mvt, i_Left_Mvt, i_Down_Mvt, i_Up_Mvt};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        debounce_filter #(
            .c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)
        ) u_debounce (
            .i_Clk       (i_Clk),
            .i_Rst_L     (i_Rst_L),
            .i_Raw       (btn_raw[g]),
            .o_Debounced (btn_level[g]),
            .o_Press     (btn_press[g])
        );
    end

    // Score feedback, column raster and the raw levels are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{i_Score, i_Col_Count_Div, btn_level};

    always_comb begin
        req_valid = |btn_press;
        req_dir   = DIR_UP;
        if (btn_press[DIR_UP])         req_dir = DIR_UP;
        else if (btn_press[DIR_DOWN])  req_dir = DIR_DOWN;
        else if (btn_press[DIR_LEFT])  req_dir = DIR_LEFT;
        else if (btn_press[DIR_RIGHT]) req_dir = DIR_RIGHT;
    end

    assign blanking = (i_Row_Count_Div >= BLANK_ROW);
    assign at_top   = (frog_y == 6'd0);
    assign hazard   = i_Collided || (i_Bitmap_Data == TILE_WATER) || at_top;
    assign goal     = !i_Collided && (i_Bitmap_Data != TILE_WATER) &&
                      at_top && (i_Bitmap_Data == TILE_LILY);

    always_comb begin
        frog_x_next  = frog_x;
        frog_y_next  = frog_y;
        score_next   = score;
        pending_next = pending;

        if (hazard) begin
            // Respawn wins over everything; any move in flight is dropped.
            frog_x_next        = START_X_V;
            frog_y_next        = START_Y_V;
            pending_next.valid = 1'b0;
            if (goal && (score < MAX_SCORE_V)) score_next = score + 7'd1;
        end else if (blanking && pending.valid) begin
            unique case (pending.dir)
                DIR_UP:    frog_y_next = step_clamp(frog_y, 1'b0, MAX_Y_V);
                DIR_DOWN:  frog_y_next = step_clamp(frog_y, 1'b1, MAX_Y_V);
                DIR_LEFT:  frog_x_next = step_clamp(frog_x, 1'b0, MAX_X_V);
                DIR_RIGHT: frog_x_next = step_clamp(frog_x, 1'b1, MAX_X_V);
                default:   ;
            endcase
            // A request landing on the commit edge queues behind it.
            pending_next.valid = req_valid;
            pending_next.dir   = req_dir;
        end else if (req_valid) begin
            pending_next.valid = 1'b1;
            pending_next.dir   = req_dir;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            frog_x  <= START_X_V;
            frog_y  <= START_Y_V;
            score   <= '0;
            pending <= '{valid: 1'b0, dir: DIR_UP};
        end else begin
            frog_x  <= frog_x_next;
            frog_y  <= frog_y_next;
            score   <= score_next;
            pending <= pending_next;
        end
    end

    assign o_Frogger_X = frog_x;
    assign o_Frogger_Y = frog_y;
    assign o_Score     = score;

endmodule

// File: tb/tb_frogger_ctrl.sv
module tb_frogger_ctrl;

    logic       clk;
    logic       rst_l;
    logic       up, down, left, right;
    logic       collided;
    logic [4:0] col_div;
    logic [4:0] row_div;
    logic [2:0] bitmap;
    logic [5:0] frog_x;
    logic [5:0] frog_y;
    logic [6:0] score;

    int errors = 0;
    int checks = 0;

    frogger_ctrl #(
        .c_DEBOUNCE_LIMIT(4)
    ) dut (
        .i_Clk           (clk),
        .i_Rst_L         (rst_l),
        .i_Score         (score),
        .i_Up_Mvt        (up),
        .i_Down_Mvt      (down),
        .i_Left_Mvt      (left),
        .i_Right_Mvt     (right),
        .i_Collided      (collided),
        .i_Col_Count_Div (col_div),
        .i_Row_Count_Div (row_div),
        .i_Bitmap_Data   (bitmap),
        .o_Frogger_X     (frog_x),
        .o_Frogger_Y     (frog_y),
        .o_Score         (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btns(input logic u, input logic d, input logic l, input logic r);
        up = u; down = d; left = l; right = r;
    endtask

    task automatic blank_tick();
        row_div = 5'd15;
        tick();
        row_div = 5'd0;
    endtask

    // Press, hold long enough to debounce, release, then one blanking cycle.
    task automatic move(input int dir);
        set_btns(dir == 0, dir == 1, dir == 2, dir == 3);
        repeat (8) tick();
        set_btns(0, 0, 0, 0);
        repeat (8) tick();
        blank_tick();
    endtask

    task automatic goal(input logic [2:0] top_tile);
        repeat (13) move(0);
        bitmap = top_tile;
        move(0);
        tick();
        bitmap = 3'd3;
    endtask

    initial begin
        rst_l = 1'b0; collided = 1'b0; col_div = 5'd0; row_div = 5'd0; bitmap = 3'd3;
        set_btns(0, 0, 0, 0);
        repeat (2) tick();
        rst_l = 1'b1;
        chk("reset_x", 32'(frog_x), 10);
        chk("reset_y", 32'(frog_y), 14);
        chk("reset_score", 32'(score), 0);

        // Single Up press: nothing until blanking, then Y-1.
        up = 1'b1;
        repeat (8) tick();
        chk("up_held_no_move", 32'(frog_y), 14);
        up = 1'b0;
        repeat (8) tick();
        chk("up_pending_no_blank", 32'(frog_y), 14);
        blank_tick();
        chk("up_commit_y", 32'(frog_y), 13);
        chk("up_commit_x", 32'(frog_x), 10);

        // Bouncing Left never stays stable long enough.
        for (int i = 0; i < 20; i++) begin
            left = ((i / 2) % 2) == 0;
            tick();
        end
        left = 1'b0;
        repeat (10) tick();
        blank_tick();
        chk("bounce_no_move", 32'(frog_x), 10);

        // Long Right hold across three blanking windows gives one move.
        right = 1'b1;
        for (int i = 0; i < 100; i++) begin
            row_div = ((i >= 20 && i < 22) || (i >= 50 && i < 52) || (i >= 80 && i < 82)) ? 5'd15 : 5'd0;
            tick();
        end
        row_div = 5'd0;
        right = 1'b0;
        repeat (10) tick();
        blank_tick();
        chk("hold_one_move", 32'(frog_x), 11);

        // Clamp at right edge.
        repeat (8) move(3);
        chk("reach_x19", 32'(frog_x), 19);
        move(3);
        chk("clamp_right", 32'(frog_x), 19);
        blank_tick();
        chk("clamp_consumed", 32'(frog_x), 19);
        move(2);
        chk("after_clamp_left", 32'(frog_x), 18);
        move(1);
        chk("down_to_14", 32'(frog_y), 14);
        move(1);
        chk("clamp_bottom", 32'(frog_y), 14);

        // Car collision at (5,9).
        repeat (13) move(2);
        repeat (5) move(0);
        chk("at_x5", 32'(frog_x), 5);
        chk("at_y9", 32'(frog_y), 9);
        collided = 1'b1;
        tick();
        collided = 1'b0;
        chk("collide_x", 32'(frog_x), 10);
        chk("collide_y", 32'(frog_y), 14);
        chk("collide_score", 32'(score), 0);

        // Water at Y=6.
        repeat (8) move(0);
        chk("at_y6", 32'(frog_y), 6);
        bitmap = 3'd2;
        tick();
        bitmap = 3'd3;
        chk("water_y", 32'(frog_y), 14);
        chk("water_x", 32'(frog_x), 10);

        // Goal on lily pad.
        repeat (13) move(0);
        bitmap = 3'd4;
        move(0);
        chk("goal_reach_y0", 32'(frog_y), 0);
        tick();
        bitmap = 3'd3;
        chk("goal_score1", 32'(score), 1);
        chk("goal_respawn_y", 32'(frog_y), 14);

        // Top row without a lily pad.
        goal(3'd0);
        chk("miss_respawn_y", 32'(frog_y), 14);
        chk("miss_score", 32'(score), 1);

        // Saturation.
        for (int i = 0; i < 98; i++) goal(3'd4);
        chk("score_99", 32'(score), 99);
        goal(3'd4);
        chk("score_sat", 32'(score), 99);
        chk("sat_respawn_y", 32'(frog_y), 14);

        // Up and Left together: Up wins.
        set_btns(1, 0, 1, 0);
        repeat (8) tick();
        set_btns(0, 0, 0, 0);
        repeat (8) tick();
        blank_tick();
        chk("simul_y", 32'(frog_y), 13);
        chk("simul_x", 32'(frog_x), 10);

        // Collision during a commit: respawn, move dropped.
        right = 1'b1;
        repeat (8) tick();
        right = 1'b0;
        repeat (8) tick();
        row_div = 5'd15;
        collided = 1'b1;
        tick();
        row_div = 5'd0;
        collided = 1'b0;
        chk("coll_commit_x", 32'(frog_x), 10);
        chk("coll_commit_y", 32'(frog_y), 14);
        blank_tick();
        chk("coll_move_dropped", 32'(frog_x), 10);

        // Reset with a move pending.
        right = 1'b1;
        repeat (8) tick();
        right = 1'b0;
        repeat (8) tick();
        rst_l = 1'b0;
        tick();
        chk("midrst_score", 32'(score), 0);
        rst_l = 1'b1;
        blank_tick();
        chk("midrst_no_move", 32'(frog_x), 10);
        move(0);
        chk("post_rst_move", 32'(frog_y), 13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frogger_ctrl.md
Name: frogger_ctrl

Overview:
- Owns the frog's tile position on the 20x15 playfield and the score.
- Debounces four direction buttons and commits one-tile moves only during vertical blanking.
- Returns the frog to start on car collision, water, or a missed goal; increments the score on reaching a lily pad.
- Sits between the top-level game module, the raster counters, the car collision check, and the score/7-segment block.

Parameters:
- c_GAME_WIDTH, 20, playfield columns (tiles).
- c_GAME_HEIGHT, 15, playfield rows (tiles); also the first blanking tile row.
- c_START_X, 10, reset/respawn column.
- c_START_Y, 14, reset/respawn row (bottom).
- c_DEBOUNCE_LIMIT, 250000, clocks a button must stay stable (10 ms at 25 MHz).
- c_MAX_SCORE, 99, score saturation value.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  synchronous active-low reset.
- i_Score  in  7  score feedback from top level; reserved, must not affect state (may be tied to o_Score).
- i_Up_Mvt / i_Down_Mvt / i_Left_Mvt / i_Right_Mvt  in  1 each  raw active-high buttons, asynchronous to logic.
- i_Collided  in  1  frog tile equals a car tile (registered upstream).
- i_Col_Count_Div  in  5  raster column / 32.
- i_Row_Count_Div  in  5  raster row / 32.
- i_Bitmap_Data  in  3  tile type at (o_Frogger_Y, o_Frogger_X), combinational from top: 0 wall, 1 road, 2 water, 3 safe, 4 lily pad.
- o_Frogger_X  out  6  frog column, registered.
- o_Frogger_Y  out  6  frog row, registered.
- o_Score  out  7  score, registered.

Behaviour:
- Reset (i_Rst_L=0 at clock edge): X=c_START_X, Y=c_START_Y, score=0, pending move cleared, debouncers cleared to 0.
- Input conditioning:
  - Each button passes a 2-flop synchronizer, then a debouncer.
  - The debounced output changes only after the synced input differs from it for c_DEBOUNCE_LIMIT consecutive clocks.
  - A move request is a 0->1 edge of a debounced signal. Holding a button produces exactly one move.
- Pending move:
  - One-entry register {valid, dir}. A new request overwrites it.
  - Simultaneous edges in one cycle use priority Up > Down > Left > Right.
- Commit:
  - When i_Row_Count_Div >= c_GAME_HEIGHT (vertical blanking) and pending is valid, apply the move on that edge and clear pending.
  - Up: Y-1. Down: Y+1. Left: X-1. Right: X+1.
  - Clamp to 0..c_GAME_WIDTH-1 and 0..c_GAME_HEIGHT-1. A move at an edge is consumed with no position change.
  - i_Col_Count_Div is used only for the blanking qualification, if at all; no other function.
- Hazard evaluation, every cycle, on the current registered position. Priority highest first:
  1. i_Collided=1: respawn to start, clear pending, score unchanged.
  2. i_Bitmap_Data==2 (water): respawn, clear pending.
  3. Y==0 and i_Bitmap_Data==4 (lily pad): score = min(score+1, c_MAX_SCORE), respawn, clear pending.
  4. Y==0 and i_Bitmap_Data!=4: respawn, no score.
- Evaluation in the same cycle as a commit:
  - Hazards are judged on the pre-commit position.
  - A hazard wins over the commit: respawn, and the move is discarded.
- Latency:
  - Respawn and score update are visible one clock after the condition.
  - A move is visible one clock after the first blanking cycle that follows the debounced edge.
- Score holds at 99 on further goals. Reset mid-operation discards all pending state immediately.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package frogger_pkg holds:
  - tile-type constants (TILE_WALL=0, TILE_ROAD=1, TILE_WATER=2, TILE_SAFE=3, TILE_LILY=4);
  - playfield dimensions;
  - direction encoding.
- One sub-module, debounce_filter (synchronizer + counter, parameter c_DEBOUNCE_LIMIT), instantiated four times.

Test Plan:
1. Reset with c_DEBOUNCE_LIMIT=4, bitmap=3, raster row 0 -> X=10, Y=14, score=0. Pulse Up for 8 clocks -> position unchanged until i_Row_Count_Div=15; one clock later Y=13.
2. Bounce: toggle Left every 2 clocks for 20 clocks, then release -> no move. Hold Right 100 clocks across 3 blanking windows -> exactly one move, X=11.
3. Clamp: X=19, press Right, blank -> X stays 19, pending cleared (a later blanking does nothing). At Y=14, press Down -> Y stays 14.
4. Hazards: i_Collided=1 at X=5, Y=9 -> next clock X=10, Y=14, score unchanged. Bitmap=2 at Y=6 -> respawn.
5. Goal: drive frog to Y=0 with bitmap=4 -> score 0->1, respawn. Y=0 with bitmap=0 -> respawn, score stays 1. Force 99 goals -> score stays 99 on the 100th.
6. Simultaneous: Up and Left edges in the same cycle -> Up applied only. Collision in the same cycle as a commit -> respawn, move discarded. Reset asserted while a move is pending -> no move after release.
